rr_burst_xfer: RTL and testbench
================================

RR_BURST_XFER -- requirements
Module: rr_burst_xfer

Interface
REQ-001 Parameter N, default 8, number of requesters; SHALL match the upstream round-robin arbiter.
REQ-002 Parameter LN, default $clog2(N), width of requester index.
REQ-003 Parameter W, default 8, data beat width.
REQ-004 Parameter MAXB, default 16, maximum beats per burst (power of two, >=2).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 arb_grant  input  LN  registered grant index from arbiter.
REQ-008 arb_valid  input  1  arbiter "any request" flag.
REQ-009 arb_en  output  1  clock-enable to arbiter; advances arbiter only while idle.
REQ-010 req_pend  input  N  request vector (same vector driving the arbiter).
REQ-011 req_data  input  N*W  per-requester beat data, requester i at bits [i*W +: W].
REQ-012 req_last  input  N  per-requester "current beat is final" flag.
REQ-013 req_pop  output  N  one-hot; bit i pulses one cycle when requester i's beat is consumed.
REQ-014 out_data  output  W  beat data to sink.
REQ-015 out_valid  output  1  beat available to sink.
REQ-016 out_ready  input  1  sink accepts beat.
REQ-017 out_src  output  LN  index of current burst owner.
REQ-018 out_last  output  1  marks final beat of burst.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states IDLE, ARM, XFER, GAP; encoding is implementation-defined.
REQ-021 IDLE: arb_en=1; if arb_valid=1, next state ARM; else remain.
REQ-022 ARM: arb_en=0; sample arb_grant; if req_pend[arb_grant]=1, latch owner<=arb_grant, clear beat counter, go XFER; else return IDLE (stale grant, no pop).
REQ-023 XFER: arb_en=0; out_valid=1; out_data=req_data[owner]; out_src=owner; out_valid SHALL NOT drop before handshake.
REQ-024 Handshake = out_valid & out_ready; on handshake req_pop[owner]=1 that same cycle (combinational), counter increments.
REQ-025 out_last=1 in XFER when req_last[owner]=1 or beat counter = MAXB-1.
REQ-026 Handshake with out_last=1: next state GAP; otherwise stay XFER.
REQ-027 GAP: one cycle, out_valid=0, arb_en=0, then IDLE; guarantees arbiter pointer advance before next grant.
REQ-028 Beat counter width $clog2(MAXB); burst truncated at MAXB beats; remaining beats are served in a later grant.
REQ-029 req_pend[owner] deasserting during XFER SHALL NOT abort the burst; termination only via out_last.
REQ-030 req_pop SHALL be zero outside handshake cycles; at most one bit high.
REQ-031 out_valid, out_last SHALL be zero in IDLE, ARM, GAP.

Reset
REQ-032 rst_n low asynchronously forces IDLE, owner=0, counter=0.
REQ-033 Reset outputs: out_valid=0, out_last=0, req_pop=0, busy=0, out_src=0, arb_en=1 (combinational from IDLE), out_data=req_data[0].
REQ-034 Reset mid-burst discards burst; no pop issued in the reset cycle.

Structure
REQ-035 Shared package holds FSM state typedef and default N/W/MAXB constants, shared with the arbiter top.
REQ-036 Single flat module; no sub-module; the arbiter is instantiated alongside, not inside.

Verification
REQ-037 N=8, req_pend=8'h04, req_last[2] high on 3rd beat, out_ready=1 -> IDLE,ARM,3 XFER cycles, req_pop[2] pulses 3x, out_last on beat 3, out_src=2, GAP, IDLE.
REQ-038 req_pend=8'h81 held, single-beat bursts -> owners alternate 0,7,0,7; no owner served twice consecutively.
REQ-039 Grant=5 but req_pend[5] drops in ARM -> return to IDLE, req_pop=0, out_valid never asserted.
REQ-040 req_last never asserted, MAXB=16 -> out_last on 16th beat, exactly 16 pops, then GAP.
REQ-041 out_ready low 4 cycles mid-burst -> out_valid/out_data stable, no pop, counter frozen.
REQ-042 rst_n low during XFER beat 2 -> immediate out_valid=0, busy=0, arb_en=1; after release, fresh ARM.

Source files
------------

// File: rtl/rr_burst_xfer_pkg.sv
// Shared types and default sizing for the round-robin burst transfer block.
// The arbiter top imports the same constants so both sides agree on N/W/MAXB.
package rr_burst_xfer_pkg;

  localparam int RRB_N    = 8;
  localparam int RRB_W    = 8;
  localparam int RRB_MAXB = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } rrb_state_e;

endpackage

// File: rtl/rr_burst_xfer_if.sv
// Bundle of the arbiter, requester and sink signals seen by rr_burst_xfer.
// master = the transfer engine, slave = the surrounding arbiter/requesters/sink.
interface rr_burst_xfer_if
  import rr_burst_xfer_pkg::*;
#(
  parameter int N  = RRB_N,
  parameter int LN = $clog2(N),
  parameter int W  = RRB_W
);

  logic [LN-1:0]  arb_grant;
  logic           arb_valid;
  logic           arb_en;
  logic [N-1:0]   req_pend;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_pop;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [LN-1:0]  out_src;
  logic           out_last;

  modport master (
    input  arb_grant, arb_valid, req_pend, req_data, req_last, out_ready,
    output arb_en, req_pop, out_data, out_valid, out_src, out_last
  );

  modport slave (
    output arb_grant, arb_valid, req_pend, req_data, req_last, out_ready,
    input  arb_en, req_pop, out_data, out_valid, out_src, out_last
  );

endinterface

// File: rtl/rr_burst_xfer.sv
// Burst transfer engine sitting beside a registered round-robin arbiter.
// IDLE lets the arbiter advance, ARM checks the grant is still wanted, XFER
// streams beats from the owner until its last flag or the MAXB limit, and GAP
// holds the arbiter for one cycle so its pointer moves before the next grant.
module rr_burst_xfer
  import rr_burst_xfer_pkg::*;
#(
  parameter int N    = RRB_N,
  parameter int LN   = $clog2(N),
  parameter int W    = RRB_W,
  parameter int MAXB = RRB_MAXB
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_burst_xfer_if.master bus,
  output logic            busy
);

  localparam int CW = $clog2(MAXB);

  rrb_state_e    state_r;
  rrb_state_e    next_state_s;
  logic [LN-1:0] owner_r;
  logic [CW-1:0] cnt_r;

  logic grant_pend_s;
  logic owner_last_s;
  logic limit_s;
  logic last_s;
  logic hs_s;
  logic take_s;

  // A grant is only honoured if that requester still asks for service.
  assign grant_pend_s = bus.req_pend[bus.arb_grant];
  assign owner_last_s = bus.req_last[owner_r];
  // Truncate at MAXB beats; the requester keeps its remaining beats for later.
  assign limit_s      = (cnt_r == CW'(MAXB - 1));
  assign last_s       = (state_r == ST_XFER) && (owner_last_s || limit_s);
  assign hs_s         = (state_r == ST_XFER) && bus.out_ready;
  assign take_s       = (state_r == ST_ARM) && grant_pend_s;

  // The data mux follows the owner register even outside a burst.
  assign bus.out_data = bus.req_data[int'(owner_r) * W +: W];
  assign bus.out_src  = owner_r;

  // Next-state selection and per-state output decode, quiet defaults first.
  always_comb begin
    next_state_s  = state_r;
    busy          = 1'b1;
    bus.arb_en    = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.req_pop   = '0;
    case (state_r)
      ST_IDLE: begin
        busy       = 1'b0;
        bus.arb_en = 1'b1;
        if (bus.arb_valid) begin
          next_state_s = ST_ARM;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (grant_pend_s) begin
          next_state_s = ST_XFER;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_s;
        if (hs_s) begin
          bus.req_pop = {{(N-1){1'b0}}, 1'b1} << owner_r;
          if (last_s) begin
            next_state_s = ST_GAP;
          end else begin
            next_state_s = ST_XFER;
          end
        end else begin
          next_state_s = ST_XFER;
        end
      end
      ST_GAP: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
        busy         = 1'b0;
        bus.arb_en   = 1'b1;
      end
    endcase
  end

  // State register; reset drops any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Owner latch on an accepted grant, beat counter advancing per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= '0;
      cnt_r   <= '0;
    end else if (take_s) begin
      owner_r <= bus.arb_grant;
      cnt_r   <= '0;
    end else if (hs_s) begin
      owner_r <= owner_r;
      cnt_r   <= cnt_r + CW'(1);
    end else begin
      owner_r <= owner_r;
      cnt_r   <= cnt_r;
    end
  end

endmodule

// File: tb/tb_rr_burst_xfer.sv
// Self-checking bench for rr_burst_xfer: a round-robin arbiter and requester
// streams live in the bench, and a behavioural model predicts every output
// on each falling edge. Directed scenarios pin the model with literal values.
`timescale 1ns/1ps
module tb_rr_burst_xfer;
  import rr_burst_xfer_pkg::*;

  localparam int N    = 8;
  localparam int LN   = 3;
  localparam int W    = 8;
  localparam int MAXB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  rr_burst_xfer_if #(.N(N), .LN(LN), .W(W)) bus ();

  rr_burst_xfer #(.N(N), .LN(LN), .W(W), .MAXB(MAXB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // requester streams and environment arbiter
  int          pos  [N];
  int          bib  [N];
  int          blen [N];
  logic [N-1:0] act;
  logic [LN-1:0] grant;
  bit          rand_mode = 1'b0;

  // values seen at the falling edge, consumed at the next rising edge
  logic [N-1:0] pop_seen  = '0;
  logic [N-1:0] pend_seen = '0;
  logic         en_seen   = 1'b0;

  // observation counters
  int pops [N];
  int n_vcyc    = 0;
  int beats_cur = 0;
  int q_own[$];
  int q_len[$];

  // behavioural model: is a burst running, who owns it, beats done, pending gap/arm
  bit m_act = 1'b0;
  bit m_gap = 1'b0;
  bit m_arm = 1'b0;
  int m_own = 0;
  int m_cnt = 0;

  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [W-1:0] beat_val(input int i, input int p);
    return W'((i * 37 + p * 11 + 3) & 255);
  endfunction

  function automatic logic [LN-1:0] rr_pick(input logic [N-1:0] r, input logic [LN-1:0] g);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (int'(g) + k) % N;
      if (r[c]) return LN'(c);
    end
    return g;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_data[i*W +: W] = beat_val(i, pos[i]);
      bus.req_last[i]        = (bib[i] == blen[i] - 1);
    end
    bus.req_pend  = act;
    bus.arb_valid = |act;
    bus.arb_grant = grant;
  endtask

  // one clock: advance arbiter and requester streams, optionally randomise
  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_n) grant = LN'(N - 1);
    else if (en_seen && (|pend_seen)) grant = rr_pick(pend_seen, grant);
    for (int i = 0; i < N; i++) begin
      if (pop_seen[i]) begin
        pos[i]++;
        bib[i]++;
        if (bib[i] >= blen[i]) begin
          bib[i] = 0;
          if (rand_mode) begin
            blen[i] = $urandom_range(1, 20);
            if ($urandom_range(0, 99) < 40) act[i] = 1'b0;
          end
        end
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (act[i]) begin
          if ($urandom_range(0, 99) < 3) act[i] = 1'b0;
        end else if ($urandom_range(0, 99) < 15) begin
          act[i] = 1'b1;
        end
      end
      bus.out_ready = ($urandom_range(0, 99) < 70);
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    act   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      bib[i]  = 0;
      blen[i] = 1;
    end
    drive();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) pops[i] = 0;
    n_vcyc = 0;
    q_own.delete();
    q_len.delete();
  endtask

  task automatic wait_bursts(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (q_own.size() < n && k < budget) begin
      step();
      k++;
    end
    check(nm, q_own.size(), n);
  endtask

  task automatic wait_pops(input int i, input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (pops[i] < n && k < budget) begin
      step();
      k++;
    end
    check(nm, pops[i], n);
  endtask

  task automatic first_valid(input string nm);
    int t;
    t = 0;
    while (!bus.out_valid && t < 10) begin
      step();
      t++;
    end
    check(nm, t, 2);
  endtask

  // per-cycle comparison against the model, then model advance
  always @(negedge clk) begin
    logic [N-1:0] exp_pop;
    logic         exp_last;
    logic         exp_busy;
    logic         hs;
    if (!rst_n) begin
      check("rst_valid", bus.out_valid, 1'b0);
      check("rst_last", bus.out_last, 1'b0);
      check("rst_pop", bus.req_pop, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_arb_en", bus.arb_en, 1'b1);
      check("rst_src", bus.out_src, 0);
      check("rst_data", bus.out_data, beat_val(0, pos[0]));
      m_act = 1'b0; m_gap = 1'b0; m_arm = 1'b0; m_own = 0; m_cnt = 0;
      beats_cur = 0;
      pop_seen  = '0;
    end else begin
      exp_busy = m_act || m_gap || m_arm;
      exp_last = m_act && (bus.req_last[m_own] || m_cnt == MAXB - 1);
      hs       = m_act && bus.out_ready;
      exp_pop  = hs ? (N'(1) << m_own) : '0;
      check("valid", bus.out_valid, m_act);
      check("last", bus.out_last, exp_last);
      check("pop", bus.req_pop, exp_pop);
      check("busy", busy, exp_busy);
      check("arb_en", bus.arb_en, !exp_busy);
      check("src", bus.out_src, m_own);
      check("data", bus.out_data, beat_val(m_own, pos[m_own]));
      // observations of the DUT for the directed scenarios
      if (bus.out_valid) n_vcyc++;
      for (int i = 0; i < N; i++) if (bus.req_pop[i]) pops[i]++;
      if (bus.out_valid && bus.out_ready) begin
        beats_cur++;
        if (bus.out_last) begin
          q_own.push_back(int'(bus.out_src));
          q_len.push_back(beats_cur);
          beats_cur = 0;
        end
      end
      // advance the model by one clock
      if (m_act) begin
        if (hs) begin
          m_cnt++;
          if (exp_last) begin
            m_act = 1'b0;
            m_gap = 1'b1;
          end
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (m_arm) begin
        m_arm = 1'b0;
        if (bus.req_pend[bus.arb_grant]) begin
          m_act = 1'b1;
          m_own = int'(bus.arb_grant);
          m_cnt = 0;
        end
      end else if (bus.arb_valid) begin
        m_arm = 1'b1;
      end
      pop_seen = bus.req_pop;
    end
    en_seen   = bus.arb_en;
    pend_seen = bus.req_pend;
  end

  initial begin
    logic [W-1:0] d0;
    for (int i = 0; i < N; i++) begin
      pos[i] = 0; bib[i] = 0; blen[i] = 1; pops[i] = 0;
    end
    act   = '0;
    grant = LN'(N - 1);
    bus.out_ready = 1'b1;
    drive();

    // single 3-beat burst from requester 2
    do_reset();
    check("idle_busy", busy, 1'b0);
    check("idle_arb_en", bus.arb_en, 1'b1);
    blen[2] = 3; act = 8'h04; drive();
    first_valid("t1_latency");
    wait_bursts(1, 20, "t1_done");
    act = '0; drive();
    check("t1_owner", q_own.size() > 0 ? q_own[0] : -1, 2);
    check("t1_len", q_len.size() > 0 ? q_len[0] : -1, 3);
    check("t1_pops", pops[2], 3);
    check("t1_gap_busy", busy, 1'b1);
    check("t1_gap_valid", bus.out_valid, 1'b0);
    step();
    check("t1_idle_busy", busy, 1'b0);

    // two requesters, single-beat bursts alternate
    do_reset();
    blen[0] = 1; blen[7] = 1; act = 8'h81; drive();
    wait_bursts(4, 60, "t2_done");
    act = '0; drive();
    for (int k = 0; k < 4; k++) begin
      check("t2_owner", q_own.size() > k ? q_own[k] : -1, (k % 2 == 0) ? 0 : 7);
      check("t2_len", q_len.size() > k ? q_len[k] : -1, 1);
    end

    // stale grant: request withdrawn while in ARM
    do_reset();
    blen[5] = 2; act = 8'h20; drive();
    step();
    check("t3_arm_busy", busy, 1'b1);
    act = '0; drive();
    repeat (5) step();
    check("t3_no_valid", n_vcyc, 0);
    check("t3_no_pop", pops[5], 0);
    check("t3_src", bus.out_src, 0);
    check("t3_idle", busy, 1'b0);

    // no last flag: burst truncated at MAXB
    do_reset();
    blen[4] = 100; act = 8'h10; drive();
    wait_bursts(1, 40, "t4_done");
    act = '0; drive();
    check("t4_owner", q_own.size() > 0 ? q_own[0] : -1, 4);
    check("t4_len", q_len.size() > 0 ? q_len[0] : -1, MAXB);
    check("t4_pops", pops[4], MAXB);
    check("t4_gap_valid", bus.out_valid, 1'b0);

    // sink stalls for 4 cycles mid-burst
    do_reset();
    blen[3] = 10; act = 8'h08; drive();
    wait_pops(3, 3, 30, "t5_pre");
    bus.out_ready = 1'b0;
    d0 = beat_val(3, 3);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t5_stall_valid", bus.out_valid, 1'b1);
      check("t5_stall_data", bus.out_data, d0);
      check("t5_stall_pop", bus.req_pop, '0);
      step();
    end
    check("t5_stall_pops", pops[3], 3);
    bus.out_ready = 1'b1;
    wait_bursts(1, 30, "t5_done");
    act = '0; drive();
    check("t5_len", q_len.size() > 0 ? q_len[0] : -1, 10);
    check("t5_pops", pops[3], 10);

    // reset during the second beat
    do_reset();
    blen[2] = 10; act = 8'h04; drive();
    wait_pops(2, 1, 20, "t6_pre");
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", bus.out_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_arb_en", bus.arb_en, 1'b1);
    check("t6_rst_pop", bus.req_pop, '0);
    step();
    rst_n = 1'b1;
    first_valid("t6_rearm");
    wait_bursts(1, 30, "t6_done");
    act = '0; drive();
    check("t6_len", q_len.size() > 0 ? q_len[0] : -1, 9);
    check("t6_pops", pops[2], 10);

    // randomised traffic checked cycle by cycle against the model
    do_reset();
    for (int i = 0; i < N; i++) blen[i] = $urandom_range(1, 20);
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    act = '0;
    bus.out_ready = 1'b1;
    drive();
    repeat (40) step();
    check("rand_bursts_seen", q_own.size() > 20, 1'b1);
    check("rand_drained", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
